// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet definitions (used by the packet assembler and disassembler).
package hdmi_packet_pkg;

    localparam int unsigned PACKET_PIXELS    = 32;
    localparam int unsigned HEADER_BITS      = 24;
    localparam int unsigned SUB_BITS         = 56;
    localparam int unsigned ECC_BITS         = 8;
    localparam int unsigned NUM_SUBS         = 4;
    localparam int unsigned PIXEL_IDX_W      = $clog2(PACKET_PIXELS);
    localparam int unsigned HEADER_WORD_BITS = HEADER_BITS + ECC_BITS;
    localparam int unsigned SUB_WORD_BITS    = SUB_BITS + ECC_BITS;

    typedef logic [HEADER_BITS-1:0] header_t;
    typedef logic [SUB_BITS-1:0]    subpacket_t;
    typedef logic [ECC_BITS-1:0]    ecc_t;
    typedef logic [PIXEL_IDX_W-1:0] pixel_idx_t;

    localparam ecc_t ECC_POLY = 8'h83;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    // One serial step of the reflected BCH parity LFSR.
    function automatic ecc_t ecc_update(input ecc_t ecc, input logic din, input ecc_t poly);
        logic fb;
        fb = din ^ ecc[0];
        return (ecc >> 1) ^ (fb ? poly : ecc_t'(0));
    endfunction

endpackage

// File: rtl/packet_disassembler_if.sv
// Data-island bus between the TERC4 decoder (master) and the packet disassembler (slave).
interface packet_disassembler_if;
    import hdmi_packet_pkg::*;

    logic                        island_active;
    logic [3:0]                  data0;
    logic [3:0]                  data1;
    logic [3:0]                  data2;
    header_t                     header;
    subpacket_t [NUM_SUBS-1:0]   sub;
    logic                        header_ok;
    logic [NUM_SUBS-1:0]         sub_ok;
    logic                        packet_valid;
    logic                        packet_abort;

    modport master (
        output island_active, data0, data1, data2,
        input  header, sub, header_ok, sub_ok, packet_valid, packet_abort
    );

    modport slave (
        input  island_active, data0, data1, data2,
        output header, sub, header_ok, sub_ok, packet_valid, packet_abort
    );

endinterface

// File: rtl/bch_ecc_step.sv
// Combinational BCH parity update over BITS_PER_STEP serial bits, bit 0 first.
module bch_ecc_step
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned BITS_PER_STEP = 1,
    parameter ecc_t        POLY          = ECC_POLY
) (
    input  ecc_t                     ecc_i,
    input  logic [BITS_PER_STEP-1:0] bits_i,
    output ecc_t                     ecc_c
);

    always_comb begin
        ecc_c = ecc_i;
        for (int unsigned k = 0; k < BITS_PER_STEP; k++) begin
            ecc_c = ecc_update(ecc_c, bits_i[k], POLY);
        end
    end

endmodule

// File: rtl/packet_disassembler.sv
// Reassembles 32-pixel HDMI data-island packets from TERC4 nibbles and checks BCH parity
// on the header and each subpacket.
module packet_disassembler
    import hdmi_packet_pkg::*;
(
    input  logic                  clk_pixel,
    input  logic                  reset,
    packet_disassembler_if.slave  bus
);

    state_t     state_q, state_d;
    pixel_idx_t count_q, count_d;

    logic [HEADER_WORD_BITS-1:0]              hdr_sr_q, hdr_sr_d;
    logic [NUM_SUBS-1:0][SUB_WORD_BITS-1:0]   sub_sr_q, sub_sr_d;
    ecc_t                                     hdr_ecc_q, hdr_ecc_d;
    ecc_t [NUM_SUBS-1:0]                      sub_ecc_q, sub_ecc_d;

    ecc_t hdr_ecc_seed_c, hdr_ecc_next_c;
    ecc_t sub_ecc_seed_c [NUM_SUBS];
    ecc_t sub_ecc_next_c [NUM_SUBS];

    header_t                   header_q, header_d;
    subpacket_t [NUM_SUBS-1:0] sub_q, sub_d;
    logic                      header_ok_q, header_ok_d;
    logic [NUM_SUBS-1:0]       sub_ok_q, sub_ok_d;
    logic                      packet_valid_q, packet_valid_d;
    logic                      packet_abort_q, packet_abort_d;

    logic capture_c, first_pixel_c, last_pixel_c, hdr_in_data_c, sub_in_data_c;
    logic unused_data0_c;

    // Sync bits and the spare channel-0 bit carry nothing for packet reassembly.
    assign unused_data0_c = ^{bus.data0[3], bus.data0[1:0]};

    assign capture_c     = bus.island_active;
    assign first_pixel_c = (count_q == '0);
    assign last_pixel_c  = capture_c && (count_q == pixel_idx_t'(PACKET_PIXELS - 1));
    assign hdr_in_data_c = (count_q < pixel_idx_t'(HEADER_BITS));
    assign sub_in_data_c = (count_q < pixel_idx_t'(SUB_BITS / 2));

    // State register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; the pixel counter wraps so back-to-back packets stay in COLLECT.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.island_active) begin
                    state_d = ST_COLLECT;
                    count_d = pixel_idx_t'(1);
                end
            end
            ST_COLLECT: begin
                if (bus.island_active) begin
                    count_d = count_q + pixel_idx_t'(1);
                end else begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Parity accumulators restart from zero on pixel 0, so no bubble between packets.
    always_comb begin
        hdr_ecc_seed_c = first_pixel_c ? ecc_t'(0) : hdr_ecc_q;
        for (int unsigned j = 0; j < NUM_SUBS; j++) begin
            sub_ecc_seed_c[j] = first_pixel_c ? ecc_t'(0) : sub_ecc_q[j];
        end
    end

    bch_ecc_step #(.BITS_PER_STEP(1), .POLY(ECC_POLY)) u_hdr_ecc (
        .ecc_i  (hdr_ecc_seed_c),
        .bits_i (bus.data0[2]),
        .ecc_c  (hdr_ecc_next_c)
    );

    for (genvar j = 0; j < NUM_SUBS; j++) begin : g_sub_ecc
        bch_ecc_step #(.BITS_PER_STEP(2), .POLY(ECC_POLY)) u_sub_ecc (
            .ecc_i  (sub_ecc_seed_c[j]),
            .bits_i ({bus.data2[j], bus.data1[j]}),
            .ecc_c  (sub_ecc_next_c[j])
        );
    end

    // Shift registers fill from the top, so pixel 0 lands in bit 0 after 32 captures.
    always_comb begin
        hdr_sr_d  = hdr_sr_q;
        sub_sr_d  = sub_sr_q;
        hdr_ecc_d = hdr_ecc_q;
        sub_ecc_d = sub_ecc_q;
        if (capture_c) begin
            hdr_sr_d = {bus.data0[2], hdr_sr_q[HEADER_WORD_BITS-1:1]};
            if (hdr_in_data_c) begin
                hdr_ecc_d = hdr_ecc_next_c;
            end
            for (int unsigned j = 0; j < NUM_SUBS; j++) begin
                sub_sr_d[j] = {bus.data2[j], bus.data1[j], sub_sr_q[j][SUB_WORD_BITS-1:2]};
                if (sub_in_data_c) begin
                    sub_ecc_d[j] = sub_ecc_next_c[j];
                end
            end
        end
    end

    // Output logic: publish a completed packet, or flag an island that ended mid-packet.
    always_comb begin
        packet_valid_d = 1'b0;
        packet_abort_d = 1'b0;
        header_d       = header_q;
        sub_d          = sub_q;
        header_ok_d    = header_ok_q;
        sub_ok_d       = sub_ok_q;
        if ((state_q == ST_COLLECT) && !bus.island_active && (count_q != '0)) begin
            packet_abort_d = 1'b1;
        end
        if (last_pixel_c) begin
            packet_valid_d = 1'b1;
            header_d       = hdr_sr_d[HEADER_BITS-1:0];
            header_ok_d    = (hdr_ecc_q == hdr_sr_d[HEADER_WORD_BITS-1:HEADER_BITS]);
            for (int unsigned j = 0; j < NUM_SUBS; j++) begin
                sub_d[j]    = sub_sr_d[j][SUB_BITS-1:0];
                sub_ok_d[j] = (sub_ecc_q[j] == sub_sr_d[j][SUB_WORD_BITS-1:SUB_BITS]);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            hdr_sr_q       <= '0;
            sub_sr_q       <= '0;
            hdr_ecc_q      <= '0;
            sub_ecc_q      <= '0;
            header_q       <= '0;
            sub_q          <= '0;
            header_ok_q    <= 1'b0;
            sub_ok_q       <= '0;
            packet_valid_q <= 1'b0;
            packet_abort_q <= 1'b0;
        end else begin
            hdr_sr_q       <= hdr_sr_d;
            sub_sr_q       <= sub_sr_d;
            hdr_ecc_q      <= hdr_ecc_d;
            sub_ecc_q      <= sub_ecc_d;
            header_q       <= header_d;
            sub_q          <= sub_d;
            header_ok_q    <= header_ok_d;
            sub_ok_q       <= sub_ok_d;
            packet_valid_q <= packet_valid_d;
            packet_abort_q <= packet_abort_d;
        end
    end

    assign bus.header       = header_q;
    assign bus.sub          = sub_q;
    assign bus.header_ok    = header_ok_q;
    assign bus.sub_ok       = sub_ok_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.packet_abort = packet_abort_q;

endmodule

// File: doc/packet_disassembler.md
# packet_disassembler

Receive-side counterpart of the HDMI packet path. Takes TERC4-decoded data-island nibbles from the three TMDS channels and reassembles each 32-pixel data-island packet into its 24-bit header and four 56-bit subpackets. Checks the BCH parity on the header and on each subpacket, and presents the result with a one-cycle strobe. Sits between the TMDS/TERC4 decoder and the packet consumers (audio sample extractor, infoframe / clock-regeneration parsers) in the sink pipeline.

## Interface
- `ECC_POLY`, 8'h83: reflected BCH generator (x^8+x^7+x^6+1) used for all parity checks.
- `clk_pixel`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `island_active`  in  1  high for every data-island pixel, excluding the leading and trailing guard bands.
- `data0`  in  4  TERC4-decoded channel 0: [0] hsync, [1] vsync, [2] header bit, [3] ignored.
- `data1`  in  4  channel 1: bit j = subpacket j, even bit.
- `data2`  in  4  channel 2: bit j = subpacket j, odd bit.
- `header`  out  24  HB2:HB1:HB0 of the last completed packet.
- `sub`  out  4x56  subpacket data bytes SB6..SB0 of the last completed packet, one entry per subpacket.
- `header_ok`  out  1  header parity matched.
- `sub_ok`  out  4  per-subpacket parity matched.
- `packet_valid`  out  1  one-cycle strobe: new packet on the outputs.
- `packet_abort`  out  1  one-cycle strobe: island ended mid-packet.

## Operation
- **States:** IDLE, COLLECT.
- **IDLE:**
  - On a cycle with `island_active` = 1: capture pixel 0, set count = 1, go to COLLECT.
- **COLLECT**, each cycle with `island_active` = 1: capture pixel `count`, increment `count` (5 bits).
  - After pixel 31 is captured: raise `packet_valid` next cycle; count wraps to 0.
  - Stay in COLLECT, so back-to-back packets need no idle cycle.
- **COLLECT with `island_active` = 0:**
  - If count != 0: pulse `packet_abort`, discard the partial packet, keep all outputs unchanged.
  - Go to IDLE in either case.
- **Bit placement at pixel i (0..31):**
  - Header bit i = `data0[2]`.
  - Subpacket j bit 2i = `data1[j]`; bit 2i+1 = `data2[j]`.
  - All fields are LSB first.
- **Header check:**
  - Bits 0..23 are data; bits 24..31 are received parity.
  - Serial ECC update per data bit: fb = bit ^ ecc[0]; ecc = (ecc >> 1) ^ (fb ? ECC_POLY : 0).
  - ecc starts at 0 for every packet.
  - `header_ok` = (computed ecc == received parity).
- **Subpacket check:**
  - Bits 0..55 are data (two ECC steps per pixel, even bit first); bits 56..63 are parity.
  - Otherwise identical to the header check.
- **Output registers:**
  - `header`, `sub`, `header_ok` and `sub_ok` update only together with `packet_valid`.
  - They hold their values until the next valid packet.
- **Ignored inputs:** `data0[3]`, hsync and vsync are not used.
- **Reset:**
  - Returns the block to IDLE with count = 0 and ECC accumulators = 0.
  - All outputs reset to 0, including `header_ok` and `sub_ok`.
  - A packet in flight is dropped silently; `packet_abort` is not asserted.

## Timing
- **Latency:** `packet_valid` is high exactly one cycle after the pixel-31 capture edge. Outputs are stable from that same cycle.
- **Abort timing:** `packet_abort` is high one cycle after the first cycle with `island_active` = 0 while count != 0.
- **Exclusivity:** `packet_valid` and `packet_abort` are never high in the same cycle.
- **Back-to-back packets:** pixel 0 of the next packet may arrive on the cycle `packet_valid` is high. The accumulators are cleared in the same cycle that pixel 0 is captured, so no bubble is needed.
- **Island ends on pixel 31:** if `island_active` drops exactly on the cycle after pixel 31, the packet is valid and there is no abort.
- **Throughput:** one packet per 32 cycles.
- **Pipelining:** no combinational path from inputs to outputs; all outputs are registered.

## Structure
- **Package `hdmi_packet_pkg`:**
  - `PACKET_PIXELS` = 32, `HEADER_BITS` = 24, `SUB_BITS` = 56, `ECC_POLY` = 8'h83.
  - Typedefs `header_t` (24b), `subpacket_t` (56b), `ecc_t` (8b).
  - Shared with the transmit-side packet assembler.
- **Sub-module `bch_ecc_step`:**
  - Parameter `BITS_PER_STEP` (1 or 2); combinational next-ECC from current ECC and incoming bits.
  - One instance for the header, four for the subpackets.

## Test plan
- **Null packet:** 32 pixels of all-zero nibbles -> `packet_valid` at cycle 33; header = 0; sub = 0; `header_ok` = 1; `sub_ok` = 4'hF.
- **Audio clock regeneration:** HB0 = 8'h01, N = 6144, CTS = 25200, with parity from the transmit-side packet assembler -> fields match bit-exact; all ok flags = 1.
- **Header parity error:** flip header bit 27 of that packet -> `header_ok` = 0; `sub_ok` = 4'hF; `header` unchanged in value.
- **Subpacket parity error:** flip subpacket 2 bit 60 -> `sub_ok` = 4'b1011.
- **Back-to-back packets:** two packets with no gap (64 active cycles) -> `packet_valid` at cycles 33 and 65; second packet's fields are correct.
- **Aborts:**
  - Drop `island_active` after pixel 17 -> `packet_abort` pulse; no `packet_valid`; outputs keep the previous packet.
  - Assert `reset` at pixel 10 -> outputs 0; no strobes; the next full packet decodes correctly.
